sram_access_controller: RTL and testbench
=========================================

Name: sram_access_controller

Overview:
- Sequences one 32-bit data-memory access from the MEM stage onto the 16-bit external SRAM as two half-word phases: low half, then high half.
- Drives `ready` low while an access is in flight; the pipeline uses `ready` to generate `freeze`.
- Sits between the MEM stage datapath (address, store data, load result) and the SRAM pins.

Parameters:
- DATA_W, 32, word width (register file width).
- SRAM_DQ_W, 16, SRAM data bus width.
- SRAM_ADDR_W, 18, SRAM address width in half-words.
- WAIT_CYCLES, 1, extra cycles each half-word phase is held (0..7).
- ADDR_BASE, 1024, byte address mapped to SRAM half-word 0.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_r_en  in  1  load request.
- mem_w_en  in  1  store request.
- addr  in  DATA_W  byte address (ALU result).
- wdata  in  DATA_W  store data (val_r_m).
- rdata  out  DATA_W  load result; registered.
- ready  out  1  high when no access is pending or the access completes this cycle.
- SRAM_DQ  inout  SRAM_DQ_W  bidirectional data bus.
- SRAM_ADDR  out  SRAM_ADDR_W  half-word address.
- SRAM_UB_N, SRAM_LB_N, SRAM_CE_N  out  1 each  held constant 0.
- SRAM_WE_N  out  1  active-low write strobe.
- SRAM_OE_N  out  1  active-low output enable.

Behaviour:
- States and transitions:
  - IDLE: on a request, go to LOW.
  - LOW: after WAIT_CYCLES+1 cycles, go to HIGH.
  - HIGH: after WAIT_CYCLES+1 cycles, go to DONE.
  - DONE: always go to IDLE after 1 cycle.
- Phase counter: 3 bits, cleared on entry to each phase.
- Request capture in IDLE: latch `op`, `addr` and `wdata`.
  - `op` = write if mem_w_en=1, else read.
  - If both enables are 1, the write wins.
  - Inputs are ignored in every other state; dropping the request mid-access does not abort it.
- Address arithmetic:
  - off = addr - ADDR_BASE, computed modulo 2^DATA_W.
  - idx = off[SRAM_ADDR_W:2]; higher bits are discarded, so addresses wrap.
  - off[1:0] is ignored.
  - SRAM_ADDR = {idx, 0} in LOW and {idx, 1} in HIGH; 0 in IDLE and DONE.
- Write phases:
  - SRAM_DQ drives wdata[15:0] in LOW and wdata[31:16] in HIGH.
  - SRAM_WE_N=0 for every cycle of the phase except the last, where it is 1 so data is held past the rising WE edge.
  - When WAIT_CYCLES=0, WE_N=0 for the single phase cycle.
  - SRAM_OE_N=1 throughout.
- Read phases:
  - SRAM_OE_N=0 and SRAM_WE_N=1.
  - SRAM_DQ is high-Z.
  - SRAM_DQ is sampled on the last cycle of LOW into rdata[15:0], and on the last cycle of HIGH into rdata[31:16].
- Bus in IDLE and DONE: SRAM_DQ high-Z, WE_N=1, OE_N=1.
- ready (combinational from state):
  - IDLE: ~(mem_r_en | mem_w_en).
  - LOW, HIGH: 0.
  - DONE: 1.
- Latency: a request seen in IDLE at cycle 0 gives ready=1 at cycle 2*(WAIT_CYCLES+1)+1. With WAIT_CYCLES=1 that is cycle 5. rdata is valid from that cycle on.
- rdata holds its value until the next read completes; writes do not change it.
- Back-to-back: the pipeline advances at DONE; a request present in the following IDLE cycle starts a new access immediately.
- Reset (any time, including mid-access):
  - State goes to IDLE and the counter clears.
  - rdata=0; latched addr, wdata and op = 0.
  - SRAM_DQ high-Z, WE_N=1, OE_N=1, SRAM_ADDR=0.
  - ready follows the IDLE rule.
  - Any partial write is left in SRAM; nothing is retried after reset.

Test Plan:
- Store 0xDEADBEEF to addr 1024, WAIT_CYCLES=1 -> SRAM half-word 0=0xBEEF, 1=0xDEAD. WE_N low exactly 1 cycle per phase. ready=0 cycles 0-4, 1 at cycle 5.
- Load from 1024 after the store above -> rdata=0xDEADBEEF at cycle 5. OE_N=0 cycles 1-4. DQ never driven by the DUT.
- Store 0x12345678 to 1028, then load from 1028 back-to-back -> SRAM[2]=0x5678, SRAM[3]=0x1234. Load returns 0x12345678. The second access starts the cycle after DONE.
- mem_r_en=mem_w_en=1, addr 1032, wdata 0xA5A5_5A5A -> performs a write: SRAM[4]=0x5A5A, SRAM[5]=0xA5A5. rdata unchanged.
- Load from 1020 -> SRAM_ADDR=0x3FFFE then 0x3FFFF (wrap). Store 0x0000FFFF to 1036, dropping mem_w_en after cycle 1 -> full write completes, SRAM[6]=0xFFFF, SRAM[7]=0x0000.
- Assert rst during HIGH of a load -> state IDLE immediately, rdata=0, DQ high-Z, WE_N=OE_N=1. With requests low, ready=1. A subsequent load completes normally.

Source files
------------

// File: rtl/sram_access_controller.sv
`default_nettype none
// ============================================================================
// Module      : sram_access_controller
// Description : Splits one 32-bit MEM-stage load or store into two 16-bit
//               external SRAM phases (low half-word, then high half-word).
//               While the access is in flight, ready is held low so the
//               pipeline can freeze.
// Ports       : clk, rst         - clock, asynchronous active-high reset
//               mem_r_en/w_en    - load / store request (a store wins a tie)
//               addr, wdata      - byte address and store data
//               rdata, ready     - registered load result, handshake
//               SRAM_*           - external asynchronous SRAM pins
// Revision    : 1.0 - initial release
// ============================================================================
module sram_access_controller #(
    parameter int DATA_W      = 32,
    parameter int SRAM_DQ_W   = 16,
    parameter int SRAM_ADDR_W = 18,
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_BASE   = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_r_en,
    input  logic                   mem_w_en,
    input  logic [DATA_W-1:0]      addr,
    input  logic [DATA_W-1:0]      wdata,
    output logic [DATA_W-1:0]      rdata,
    output logic                   ready,
    inout  wire  [SRAM_DQ_W-1:0]   SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_OE_N
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [2:0]        c_last_cnt  = 3'(WAIT_CYCLES);
    localparam logic [DATA_W-1:0] c_addr_base = DATA_W'(ADDR_BASE);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [2:0]            r_cnt;
    logic                  r_op_write;
    logic [DATA_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W-1:0]     r_rdata;

    logic                  w_req;
    logic                  w_last;
    logic [DATA_W-1:0]     w_off;
    logic [SRAM_ADDR_W-2:0] w_idx;
    logic                  w_dq_oe;
    logic [SRAM_DQ_W-1:0]  w_dq_out;
    logic                  w_unused_off;

    assign w_req  = mem_r_en | mem_w_en;
    assign w_last = (r_cnt == c_last_cnt);

    // Byte offset from the SRAM window base; the word index drops the
    // byte-lane bits and everything above the SRAM span, so addresses wrap.
    assign w_off        = r_addr - c_addr_base;
    assign w_idx        = w_off[SRAM_ADDR_W:2];
    assign w_unused_off = ^{w_off[DATA_W-1:SRAM_ADDR_W+1], w_off[1:0]};

    // ------------------------------------------------------------------
    // State register, phase counter and request capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 3'd0;
            r_op_write <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= 3'd0;
                    if (w_req) begin
                        r_op_write <= mem_w_en;
                        r_addr     <= addr;
                        r_wdata    <= wdata;
                    end
                end
                ST_LOW, ST_HIGH: begin
                    // Counter restarts at each phase boundary
                    r_cnt <= w_last ? 3'd0 : r_cnt + 3'd1;
                end
                default: begin
                    r_cnt <= 3'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Load result: each half is sampled on the final cycle of its phase,
    // giving the SRAM the full phase to settle its output.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (!r_op_write && w_last) begin
            if (r_state == ST_LOW) begin
                r_rdata[SRAM_DQ_W-1:0] <= SRAM_DQ;
            end else if (r_state == ST_HIGH) begin
                r_rdata[2*SRAM_DQ_W-1:SRAM_DQ_W] <= SRAM_DQ;
            end
        end
    end

    assign rdata = r_rdata;

    // ------------------------------------------------------------------
    // Next state and pin outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        ready       = 1'b0;
        SRAM_ADDR   = '0;
        SRAM_WE_N   = 1'b1;
        SRAM_OE_N   = 1'b1;
        w_dq_oe     = 1'b0;
        w_dq_out    = '0;

        case (r_state)
            ST_IDLE: begin
                ready = ~w_req;
                if (w_req) begin
                    w_state_nxt = ST_LOW;
                end
            end
            ST_LOW: begin
                SRAM_ADDR = {w_idx, 1'b0};
                if (r_op_write) begin
                    w_dq_oe  = 1'b1;
                    w_dq_out = r_wdata[SRAM_DQ_W-1:0];
                    // Release WE one cycle early so data is held past the
                    // rising strobe; a single-cycle phase has no slack.
                    SRAM_WE_N = (WAIT_CYCLES != 0) && w_last;
                end else begin
                    SRAM_OE_N = 1'b0;
                end
                if (w_last) begin
                    w_state_nxt = ST_HIGH;
                end
            end
            ST_HIGH: begin
                SRAM_ADDR = {w_idx, 1'b1};
                if (r_op_write) begin
                    w_dq_oe   = 1'b1;
                    w_dq_out  = r_wdata[2*SRAM_DQ_W-1:SRAM_DQ_W];
                    SRAM_WE_N = (WAIT_CYCLES != 0) && w_last;
                end else begin
                    SRAM_OE_N = 1'b0;
                end
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                ready       = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign SRAM_DQ   = w_dq_oe ? w_dq_out : {SRAM_DQ_W{1'bz}};
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_sram_access_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_access_controller
// Description : Directed bench for sram_access_controller with a behavioural
//               16-bit asynchronous SRAM attached to the pins.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_access_controller;

    logic        clk;
    logic        rst;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_ub_n;
    logic        sram_lb_n;
    logic        sram_ce_n;
    logic        sram_we_n;
    logic        sram_oe_n;

    int n_checks = 0;
    int n_errors = 0;
    int cyc_cnt  = 0;

    logic [15:0] mem [0:262143];

    sram_access_controller #(
        .DATA_W      (32),
        .SRAM_DQ_W   (16),
        .SRAM_ADDR_W (18),
        .WAIT_CYCLES (1),
        .ADDR_BASE   (1024)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_r_en  (mem_r_en),
        .mem_w_en  (mem_w_en),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .ready     (ready),
        .SRAM_DQ   (sram_dq),
        .SRAM_ADDR (sram_addr),
        .SRAM_UB_N (sram_ub_n),
        .SRAM_LB_N (sram_lb_n),
        .SRAM_CE_N (sram_ce_n),
        .SRAM_WE_N (sram_we_n),
        .SRAM_OE_N (sram_oe_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Behavioural SRAM: drives the bus when output-enabled, stores while WE low
    assign sram_dq = (!sram_oe_n && !sram_ce_n) ? mem[sram_addr] : 16'bz;
    always @(posedge clk) begin
        if (!sram_we_n && !sram_ce_n) mem[sram_addr] <= sram_dq;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One access starting at the next IDLE cycle (cycle 0). Samples 1ns after
    // each falling edge; stops at the first cycle with ready=1 or a bound.
    task automatic access(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input int drop_at,
                          output int rdy_at, output int we_lo, output int oe_lo,
                          output logic [17:0] a_lo, output logic [17:0] a_hi,
                          output int t0, output int t_done);
        @(negedge clk);
        mem_r_en = r; mem_w_en = w; addr = a; wdata = d;
        t0 = cyc_cnt; t_done = -1; rdy_at = -1;
        we_lo = 0; oe_lo = 0; a_lo = '0; a_hi = '0;
        for (int c = 0; c <= 20; c++) begin
            if (c > 0) begin
                @(negedge clk);
                if (c == drop_at) begin
                    mem_r_en = 1'b0; mem_w_en = 1'b0;
                end
            end
            #1;
            if (!sram_we_n) we_lo++;
            if (!sram_oe_n) oe_lo++;
            if (c == 1) a_lo = sram_addr;
            if (c == 3) a_hi = sram_addr;
            if (ready) begin
                rdy_at = c; t_done = cyc_cnt;
                break;
            end
        end
        mem_r_en = 1'b0; mem_w_en = 1'b0;
    endtask

    int          rdy_at, we_lo, oe_lo, t0, t_done, t_prev_done;
    logic [17:0] a_lo, a_hi;

    initial begin
        rst = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0; addr = '0; wdata = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_ready", {31'd0, ready}, 32'd1);
        check("reset_rdata", rdata, 32'd0);
        check("reset_we_oe", {30'd0, sram_we_n, sram_oe_n}, 32'd3);
        check("reset_addr", {14'd0, sram_addr}, 32'd0);
        check("tie_offs", {29'd0, sram_ub_n, sram_lb_n, sram_ce_n}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Store 0xDEADBEEF to 1024
        access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, -1, rdy_at, we_lo, oe_lo, a_lo, a_hi, t0, t_done);
        check("st1_ready_cyc", rdy_at, 32'd5);
        check("st1_we_low_cycles", we_lo, 32'd2);
        check("st1_oe_low_cycles", oe_lo, 32'd0);
        check("st1_addr_lo", {14'd0, a_lo}, 32'd0);
        check("st1_addr_hi", {14'd0, a_hi}, 32'd1);
        check("st1_mem0", {16'd0, mem[0]}, 32'h0000BEEF);
        check("st1_mem1", {16'd0, mem[1]}, 32'h0000DEAD);

        // Load back from 1024
        access(1'b1, 1'b0, 32'd1024, 32'd0, -1, rdy_at, we_lo, oe_lo, a_lo, a_hi, t0, t_done);
        check("ld1_ready_cyc", rdy_at, 32'd5);
        check("ld1_rdata", rdata, 32'hDEADBEEF);
        check("ld1_oe_low_cycles", oe_lo, 32'd4);
        check("ld1_we_low_cycles", we_lo, 32'd0);

        // Store then load 1028 back-to-back
        access(1'b0, 1'b1, 32'd1028, 32'h12345678, -1, rdy_at, we_lo, oe_lo, a_lo, a_hi, t0, t_done);
        t_prev_done = t_done;
        check("st2_ready_cyc", rdy_at, 32'd5);
        access(1'b1, 1'b0, 32'd1028, 32'd0, -1, rdy_at, we_lo, oe_lo, a_lo, a_hi, t0, t_done);
        check("b2b_gap", t0 - t_prev_done, 32'd1);
        check("ld2_ready_cyc", rdy_at, 32'd5);
        check("st2_mem2", {16'd0, mem[2]}, 32'h00005678);
        check("st2_mem3", {16'd0, mem[3]}, 32'h00001234);
        check("ld2_rdata", rdata, 32'h12345678);

        // Both enables: store wins, rdata untouched
        access(1'b1, 1'b1, 32'd1032, 32'hA5A55A5A, -1, rdy_at, we_lo, oe_lo, a_lo, a_hi, t0, t_done);
        check("both_we_low_cycles", we_lo, 32'd2);
        check("both_mem4", {16'd0, mem[4]}, 32'h00005A5A);
        check("both_mem5", {16'd0, mem[5]}, 32'h0000A5A5);
        check("both_rdata_kept", rdata, 32'h12345678);

        // Address below base wraps to the top of the SRAM
        access(1'b1, 1'b0, 32'd1020, 32'd0, -1, rdy_at, we_lo, oe_lo, a_lo, a_hi, t0, t_done);
        check("wrap_addr_lo", {14'd0, a_lo}, 32'h0003FFFE);
        check("wrap_addr_hi", {14'd0, a_hi}, 32'h0003FFFF);

        // Request dropped mid-access still completes the store
        access(1'b0, 1'b1, 32'd1036, 32'h0000FFFF, 2, rdy_at, we_lo, oe_lo, a_lo, a_hi, t0, t_done);
        check("drop_ready_cyc", rdy_at, 32'd5);
        check("drop_mem6", {16'd0, mem[6]}, 32'h0000FFFF);
        check("drop_mem7", {16'd0, mem[7]}, 32'h00000000);
        access(1'b1, 1'b0, 32'd1036, 32'd0, -1, rdy_at, we_lo, oe_lo, a_lo, a_hi, t0, t_done);
        check("drop_rdata", rdata, 32'h0000FFFF);

        // Reset during the HIGH phase of a load
        @(negedge clk);
        mem_r_en = 1'b1; addr = 32'd1024;
        repeat (3) @(negedge clk);
        #1;
        check("rst_pre_high_oe", {31'd0, sram_oe_n}, 32'd0);
        check("rst_pre_high_addr", {14'd0, sram_addr}, 32'd1);
        mem_r_en = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_mid_ready", {31'd0, ready}, 32'd1);
        check("rst_mid_rdata", rdata, 32'd0);
        check("rst_mid_we_oe", {30'd0, sram_we_n, sram_oe_n}, 32'd3);
        check("rst_mid_addr", {14'd0, sram_addr}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        access(1'b1, 1'b0, 32'd1024, 32'd0, -1, rdy_at, we_lo, oe_lo, a_lo, a_hi, t0, t_done);
        check("post_rst_ready_cyc", rdy_at, 32'd5);
        check("post_rst_rdata", rdata, 32'hDEADBEEF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
